// File: rtl/mac_pkg.sv
// Shared constants and elaboration helpers for the pipelined multiply-accumulate.
package mac_pkg;

    localparam int MAC_MAX_W = 128;

    function automatic int mac_min_acc_w(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

    function automatic logic [MAC_MAX_W-1:0] mac_sat_max(input int acc_w, input bit is_signed);
        if (is_signed)
            return (MAC_MAX_W'(1) << (acc_w - 1)) - MAC_MAX_W'(1);
        return (MAC_MAX_W'(1) << acc_w) - MAC_MAX_W'(1);
    endfunction

    function automatic logic [MAC_MAX_W-1:0] mac_sat_min(input int acc_w, input bit is_signed);
        if (is_signed)
            return MAC_MAX_W'(1) << (acc_w - 1);
        return '0;
    endfunction

    function automatic int mac_lane_lo(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One registered multiplier lane; the product register only loads when en is high.
module mac_lane_mult
    import mac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod
);

    localparam int PROD_W = 2 * DATA_W;
    localparam bit IS_SIGNED = (SIGNED != 0);

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] prod_q;

    // Extending to the full product width first makes one multiplier serve both signednesses.
    always_comb begin
        a_ext  = {{DATA_W{IS_SIGNED & a[DATA_W-1]}}, a};
        b_ext  = {{DATA_W{IS_SIGNED & b[DATA_W-1]}}, b};
        prod_d = en ? (a_ext * b_ext) : prod_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            prod_q <= '0;
        else
            prod_q <= prod_d;
    end

    assign prod = prod_q;

endmodule

// File: rtl/mac_pipe.sv
// Two-stage multiply-accumulate: LANES registered products summed into one
// accumulator with optional saturation, sticky overflow and a result strobe.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 1,
    parameter int ACC_W  = 64,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      en,
    input  logic [LANES*DATA_W-1:0]   A,
    input  logic [LANES*DATA_W-1:0]   B,
    output logic [ACC_W-1:0]          accum,
    output logic                      ovf,
    output logic                      out_vld,
    output logic [15:0]               acc_cnt
);

    localparam int PROD_W    = 2 * DATA_W;
    localparam int MIN_ACC_W = mac_min_acc_w(DATA_W, LANES);
    localparam int EXT_W     = ACC_W + 1 - PROD_W;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam bit IS_SAT    = (SAT != 0);
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(mac_sat_max(ACC_W, IS_SIGNED));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(mac_sat_min(ACC_W, IS_SIGNED));

    if (ACC_W < MIN_ACC_W) begin : g_acc_w_check
        $error("mac_pipe: ACC_W too small for DATA_W and LANES");
    end

    logic [PROD_W-1:0] prod [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane_mult #(
            .DATA_W (DATA_W),
            .SIGNED (SIGNED)
        ) u_mult (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .a     (A[mac_lane_lo(i, DATA_W) +: DATA_W]),
            .b     (B[mac_lane_lo(i, DATA_W) +: DATA_W]),
            .prod  (prod[i])
        );
    end

    logic              en_stg2_d, en_stg2_q;
    logic [ACC_W-1:0]  accum_d, accum_q;
    logic              ovf_d, ovf_q;
    logic              out_vld_d, out_vld_q;
    logic [15:0]       acc_cnt_d, acc_cnt_q;

    logic [ACC_W:0]    sum_ext;
    logic [ACC_W:0]    acc_ext;
    logic [ACC_W:0]    nxt;
    logic              ovf_now;

    always_comb begin
        sum_ext = '0;
        for (int i = 0; i < LANES; i++)
            sum_ext = sum_ext + {{EXT_W{IS_SIGNED & prod[i][PROD_W-1]}}, prod[i]};
    end

    // One spare bit above the accumulator: it is the carry when unsigned and the true sign when signed.
    always_comb begin
        en_stg2_d = en & ~clr;
        acc_ext   = {IS_SIGNED & accum_q[ACC_W-1], accum_q};
        nxt       = acc_ext + sum_ext;
        ovf_now   = IS_SIGNED ? (nxt[ACC_W] ^ nxt[ACC_W-1]) : nxt[ACC_W];

        accum_d   = accum_q;
        ovf_d     = ovf_q;
        acc_cnt_d = acc_cnt_q;
        out_vld_d = 1'b0;

        if (clr) begin
            accum_d   = '0;
            ovf_d     = 1'b0;
            acc_cnt_d = '0;
        end else if (en_stg2_q) begin
            out_vld_d = 1'b1;
            if (ovf_now && IS_SAT)
                accum_d = (IS_SIGNED && nxt[ACC_W]) ? SAT_MIN : SAT_MAX;
            else
                accum_d = nxt[ACC_W-1:0];
            ovf_d = ovf_q | ovf_now;
            if (acc_cnt_q != 16'hFFFF)
                acc_cnt_d = acc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_stg2_q <= 1'b0;
            accum_q   <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
            acc_cnt_q <= '0;
        end else begin
            en_stg2_q <= en_stg2_d;
            accum_q   <= accum_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign accum   = accum_q;
    assign ovf     = ovf_q;
    assign out_vld = out_vld_q;
    assign acc_cnt = acc_cnt_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: five parameterisations run side by side against an integer-arithmetic reference model.
module tb_mac_pipe;

    typedef logic signed [127:0] big_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, en;
    logic [15:0] a16, b16;
    logic [31:0] a32, b32;

    logic [63:0] acc_def;
    logic [31:0] acc_usat, acc_uwrap;
    logic [19:0] acc_ssat, acc_swrap;
    logic [4:0]  ovf_v, vld_v;
    logic [4:0][15:0] cnt_v;
    logic [127:0] d_acc [5];

    // inst 0: defaults, 1: unsigned sat 32b, 2: unsigned wrap 32b, 3: signed 4x8 sat 20b, 4: signed 4x8 wrap 20b
    int p_dw    [5] = '{16, 16, 16, 8, 8};
    int p_lanes [5] = '{1, 1, 1, 4, 4};
    int p_accw  [5] = '{64, 32, 32, 20, 20};
    int p_sgn   [5] = '{0, 0, 0, 1, 1};
    int p_sat   [5] = '{0, 1, 0, 1, 0};

    mac_pipe u_def (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .A(a16), .B(b16),
        .accum(acc_def), .ovf(ovf_v[0]), .out_vld(vld_v[0]), .acc_cnt(cnt_v[0]));

    mac_pipe #(.DATA_W(16), .LANES(1), .ACC_W(32), .SIGNED(0), .SAT(1)) u_usat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .A(a16), .B(b16),
        .accum(acc_usat), .ovf(ovf_v[1]), .out_vld(vld_v[1]), .acc_cnt(cnt_v[1]));

    mac_pipe #(.DATA_W(16), .LANES(1), .ACC_W(32), .SIGNED(0), .SAT(0)) u_uwrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .A(a16), .B(b16),
        .accum(acc_uwrap), .ovf(ovf_v[2]), .out_vld(vld_v[2]), .acc_cnt(cnt_v[2]));

    mac_pipe #(.DATA_W(8), .LANES(4), .ACC_W(20), .SIGNED(1), .SAT(1)) u_ssat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .A(a32), .B(b32),
        .accum(acc_ssat), .ovf(ovf_v[3]), .out_vld(vld_v[3]), .acc_cnt(cnt_v[3]));

    mac_pipe #(.DATA_W(8), .LANES(4), .ACC_W(20), .SIGNED(1), .SAT(0)) u_swrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .A(a32), .B(b32),
        .accum(acc_swrap), .ovf(ovf_v[4]), .out_vld(vld_v[4]), .acc_cnt(cnt_v[4]));

    assign d_acc[0] = 128'(acc_def);
    assign d_acc[1] = 128'(acc_usat);
    assign d_acc[2] = 128'(acc_uwrap);
    assign d_acc[3] = 128'(acc_ssat);
    assign d_acc[4] = 128'(acc_swrap);

    int checks = 0;
    int errors = 0;

    // Reference model: accumulator kept as a mathematical integer, products queued one cycle.
    big_t m_acc [5];
    big_t m_pend [5];
    bit   m_pend_v [5];
    bit   m_ovf [5];
    bit   m_vld [5];
    int   m_cnt [5];

    function automatic big_t maskof(int k);
        return (big_t'(1) <<< p_accw[k]) - big_t'(1);
    endfunction

    function automatic big_t exp_acc(int k);
        return m_acc[k] & maskof(k);
    endfunction

    function automatic big_t opval(logic [31:0] v, int lane, int w, bit s);
        big_t x;
        x = big_t'((v >> (lane * w)) & ((32'd1 << w) - 32'd1));
        if (s && x[w-1])
            x = x - (big_t'(1) <<< w);
        return x;
    endfunction

    function automatic big_t prod_sum(int k);
        logic [31:0] a, b;
        big_t s;
        a = (k < 3) ? {16'h0, a16} : a32;
        b = (k < 3) ? {16'h0, b16} : b32;
        s = 0;
        for (int i = 0; i < p_lanes[k]; i++)
            s = s + opval(a, i, p_dw[k], p_sgn[k] != 0) * opval(b, i, p_dw[k], p_sgn[k] != 0);
        return s;
    endfunction

    task automatic tick();
        big_t t, hi, lo, mask;
        for (int k = 0; k < 5; k++) begin
            mask = maskof(k);
            hi   = (p_sgn[k] != 0) ? (mask >>> 1) : mask;
            lo   = (p_sgn[k] != 0) ? -(hi + 1) : big_t'(0);
            if (!rst_n) begin
                m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_vld[k] = 0;
                m_pend[k] = 0; m_pend_v[k] = 0;
            end else begin
                if (clr) begin
                    m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_vld[k] = 0;
                end else if (m_pend_v[k]) begin
                    t = m_acc[k] + m_pend[k];
                    if (t > hi || t < lo) begin
                        m_ovf[k] = 1;
                        if (p_sat[k] != 0) begin
                            t = (t > hi) ? hi : lo;
                        end else begin
                            t = t & mask;
                            if (t > hi) t = t - (mask + 1);
                        end
                    end
                    m_acc[k] = t;
                    m_cnt[k] = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
                    m_vld[k] = 1;
                end else begin
                    m_vld[k] = 0;
                end
                if (en) m_pend[k] = prod_sum(k);
                m_pend_v[k] = en && !clr;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; clr = 0; en = 0; a16 = 0; b16 = 0; a32 = 0; b32 = 0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (d_acc[k] !== 128'd0 || ovf_v[k] !== 1'b0 || vld_v[k] !== 1'b0 || cnt_v[k] !== 16'd0) begin
                errors++;
                $display("FAIL reset inst%0d: accum=%h ovf=%b vld=%b cnt=%0d, expected all zero",
                         k, d_acc[k], ovf_v[k], vld_v[k], cnt_v[k]);
            end
        end
    endtask

    task automatic test_single();
        rst_n = 1; a16 = 16'd3; b16 = 16'd5; en = 1;
        tick();
        checks++;
        if (vld_v[0] !== 1'b0) begin
            errors++; $display("FAIL single_early_vld: out_vld=%b, expected 0", vld_v[0]);
        end
        en = 0;
        tick();
        checks++;
        if (acc_def !== 64'd15 || vld_v[0] !== 1'b1 || cnt_v[0] !== 16'd1 || ovf_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_result: accum=%0d vld=%b cnt=%0d ovf=%b, expected 15 1 1 0",
                     acc_def, vld_v[0], cnt_v[0], ovf_v[0]);
        end
        tick();
        checks++;
        if (vld_v[0] !== 1'b0 || acc_def !== 64'd15) begin
            errors++; $display("FAIL single_pulse: vld=%b accum=%0d, expected 0 15", vld_v[0], acc_def);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (d_acc[k] !== exp_acc(k) || ovf_v[k] !== m_ovf[k] || vld_v[k] !== m_vld[k] || cnt_v[k] !== 16'(m_cnt[k])) begin
                errors++;
                $display("FAIL single_model inst%0d: accum=%h ovf=%b vld=%b cnt=%0d, expected %h %b %b %0d",
                         k, d_acc[k], ovf_v[k], vld_v[k], cnt_v[k], exp_acc(k), m_ovf[k], m_vld[k], m_cnt[k]);
            end
        end
    endtask

    task automatic test_signed_lanes();
        logic [19:0] e20;
        clr = 1; en = 0;
        tick();
        clr = 0; en = 1; a16 = 0; b16 = 0;
        a32 = {8'h02, 8'hFD, 8'h04, 8'hFF};
        b32 = {8'h07, 8'h07, 8'hFE, 8'h0A};
        for (int s = 1; s <= 5; s++) begin
            if (s == 4) en = 0;
            tick();
            if (s >= 2 && s <= 4) begin
                e20 = 20'(-25 * (s - 1));
                checks++;
                if (acc_ssat !== e20 || acc_swrap !== e20 || vld_v[3] !== 1'b1 || vld_v[4] !== 1'b1) begin
                    errors++;
                    $display("FAIL signed_lanes step%0d: accum=%h/%h vld=%b%b, expected %h vld=11",
                             s, acc_ssat, acc_swrap, vld_v[3], vld_v[4], e20);
                end
            end else if (s == 5) begin
                checks++;
                if (vld_v[3] !== 1'b0) begin
                    errors++; $display("FAIL signed_lanes_end: vld=%b, expected 0", vld_v[3]);
                end
            end
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (d_acc[k] !== exp_acc(k) || ovf_v[k] !== m_ovf[k] || vld_v[k] !== m_vld[k] || cnt_v[k] !== 16'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL signed_model inst%0d: accum=%h ovf=%b vld=%b cnt=%0d, expected %h %b %b %0d",
                             k, d_acc[k], ovf_v[k], vld_v[k], cnt_v[k], exp_acc(k), m_ovf[k], m_vld[k], m_cnt[k]);
                end
            end
        end
    endtask

    task automatic test_sat_wrap();
        clr = 1; en = 0;
        tick();
        clr = 0; en = 1;
        a16 = 16'hFFFF; b16 = 16'hFFFF;
        a32 = 32'h80808080; b32 = 32'h80808080;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) b32 = 32'h7F7F7F7F;
            tick();
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (d_acc[k] !== exp_acc(k) || ovf_v[k] !== m_ovf[k] || vld_v[k] !== m_vld[k] || cnt_v[k] !== 16'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL sat_model c%0d inst%0d: accum=%h ovf=%b vld=%b cnt=%0d, expected %h %b %b %0d",
                             c, k, d_acc[k], ovf_v[k], vld_v[k], cnt_v[k], exp_acc(k), m_ovf[k], m_vld[k], m_cnt[k]);
                end
            end
            if (c == 9) begin
                checks++;
                if (acc_ssat !== 20'h7FFFF || ovf_v[3] !== 1'b1) begin
                    errors++; $display("FAIL ssat_max: accum=%h ovf=%b, expected 7ffff 1", acc_ssat, ovf_v[3]);
                end
            end
        end
        checks++;
        if (acc_usat !== 32'hFFFF_FFFF || ovf_v[1] !== 1'b1 || ovf_v[2] !== 1'b1) begin
            errors++;
            $display("FAIL usat_rail: accum=%h ovf=%b wrap_ovf=%b, expected ffffffff 1 1", acc_usat, ovf_v[1], ovf_v[2]);
        end
        checks++;
        if (acc_ssat !== 20'h80000 || ovf_v[3] !== 1'b1) begin
            errors++; $display("FAIL ssat_min: accum=%h ovf=%b, expected 80000 1", acc_ssat, ovf_v[3]);
        end
    endtask

    task automatic test_clr();
        int exp_seq [8] = '{1, 2, 3, 0, 0, 1, 2, 3};
        clr = 1; en = 0;
        tick();
        clr = 0; en = 1; a16 = 1; b16 = 1; a32 = 32'h01010101; b32 = 32'h01010101;
        tick();
        for (int s = 0; s < 8; s++) begin
            clr = (s == 3);
            tick();
            checks++;
            if (acc_def !== 64'(exp_seq[s]) || cnt_v[0] !== 16'(exp_seq[s]) || vld_v[0] !== (exp_seq[s] != 0)) begin
                errors++;
                $display("FAIL clr_seq step%0d: accum=%0d cnt=%0d vld=%b, expected %0d %0d %b",
                         s, acc_def, cnt_v[0], vld_v[0], exp_seq[s], exp_seq[s], exp_seq[s] != 0);
            end
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (d_acc[k] !== exp_acc(k) || ovf_v[k] !== m_ovf[k] || vld_v[k] !== m_vld[k] || cnt_v[k] !== 16'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL clr_model inst%0d: accum=%h ovf=%b vld=%b cnt=%0d, expected %h %b %b %0d",
                             k, d_acc[k], ovf_v[k], vld_v[k], cnt_v[k], exp_acc(k), m_ovf[k], m_vld[k], m_cnt[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 23) == 0);
            a16 = 16'($urandom); b16 = 16'($urandom);
            a32 = $urandom; b32 = $urandom;
            tick();
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (d_acc[k] !== exp_acc(k) || ovf_v[k] !== m_ovf[k] || vld_v[k] !== m_vld[k] || cnt_v[k] !== 16'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d: accum=%h ovf=%b vld=%b cnt=%0d, expected %h %b %b %0d",
                             c, k, d_acc[k], ovf_v[k], vld_v[k], cnt_v[k], exp_acc(k), m_ovf[k], m_vld[k], m_cnt[k]);
                end
            end
        end
        clr = 0;
    endtask

    task automatic test_reset_midrun();
        en = 1; clr = 0; a16 = 16'd7; b16 = 16'd9; a32 = 32'h05050505; b32 = 32'h03030303;
        tick();
        tick();
        tick();
        rst_n = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (d_acc[k] !== 128'd0 || ovf_v[k] !== 1'b0 || vld_v[k] !== 1'b0 || cnt_v[k] !== 16'd0) begin
                errors++;
                $display("FAIL midrun_reset inst%0d: accum=%h ovf=%b vld=%b cnt=%0d, expected all zero",
                         k, d_acc[k], ovf_v[k], vld_v[k], cnt_v[k]);
            end
        end
        rst_n = 1; en = 0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (vld_v[k] !== 1'b0 || d_acc[k] !== 128'd0 || cnt_v[k] !== 16'd0) begin
                errors++;
                $display("FAIL midrun_after inst%0d: vld=%b accum=%h cnt=%0d, expected 0 0 0",
                         k, vld_v[k], d_acc[k], cnt_v[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed_lanes();
        test_sat_wrap();
        test_clr();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
